// File: rtl/id_ex_if.sv
// ============================================================================
// Module      : id_ex_if
// Description : Bundle of ID-stage inputs and EX-stage registered outputs for
//               the ID/EX pipeline register. bubble_cnt exists only when the
//               ID_EX_PERF_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_if;

    // ID-side control bits (already through the load-use flush mux)
    logic        regDst;
    logic        memRead;
    logic        memtoReg;
    logic        memWrite;
    logic        aluSrc;
    logic        regWrite;
    logic [1:0]  aluop;

    // ID-side data and register numbers
    logic [31:0] pc4;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    // Pipeline qualifiers
    logic        id_valid;
    logic        flush;
    logic        hold;

    // EX-side registered copies
    logic        regDst_ex;
    logic        memRead_ex;
    logic        memtoReg_ex;
    logic        memWrite_ex;
    logic        aluSrc_ex;
    logic        regWrite_ex;
    logic [1:0]  aluop_ex;
    logic [31:0] pc4_ex;
    logic [31:0] rdata1_ex;
    logic [31:0] rdata2_ex;
    logic [31:0] imm_ex;
    logic [4:0]  rs_ex;
    logic [4:0]  rt_ex;
    logic [4:0]  rd_ex;
    logic        ex_valid;
    logic        ex_load;

`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt;
`endif

    // ID stage / testbench side: drives the inputs, observes the outputs
    modport master (
`ifdef ID_EX_PERF_EN
        input  bubble_cnt,
`endif
        output regDst, memRead, memtoReg, memWrite, aluSrc, regWrite, aluop,
        output pc4, rdata1, rdata2, imm, rs, rt, rd,
        output id_valid, flush, hold,
        input  regDst_ex, memRead_ex, memtoReg_ex, memWrite_ex, aluSrc_ex,
        input  regWrite_ex, aluop_ex,
        input  pc4_ex, rdata1_ex, rdata2_ex, imm_ex, rs_ex, rt_ex, rd_ex,
        input  ex_valid, ex_load
    );

    // Pipeline register side
    modport slave (
`ifdef ID_EX_PERF_EN
        output bubble_cnt,
`endif
        input  regDst, memRead, memtoReg, memWrite, aluSrc, regWrite, aluop,
        input  pc4, rdata1, rdata2, imm, rs, rt, rd,
        input  id_valid, flush, hold,
        output regDst_ex, memRead_ex, memtoReg_ex, memWrite_ex, aluSrc_ex,
        output regWrite_ex, aluop_ex,
        output pc4_ex, rdata1_ex, rdata2_ex, imm_ex, rs_ex, rt_ex, rd_ex,
        output ex_valid, ex_load
    );

endinterface

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register. Per-edge priority is
//               flush > hold > normal load; id_valid=0 captures a bubble with
//               all control bits cleared. Asynchronous active-low reset.
//               Optional macro ID_EX_PERF_EN adds a saturating 16-bit bubble
//               counter on bus.bubble_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_reg (
    input  wire logic clk,
    input  wire logic rst_n,
    id_ex_if.slave    bus
);

    // Control vector bit order: {regDst, memRead, memtoReg, memWrite, aluSrc, regWrite}
    localparam int unsigned c_CTRL_W    = 6;
    localparam int unsigned c_MEMREAD_B = 4;

    logic [c_CTRL_W-1:0] w_ctrl_in;
    logic [c_CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [1:0]          aluop_q,  aluop_d;
    logic [31:0]         pc4_q,    pc4_d;
    logic [31:0]         rdata1_q, rdata1_d;
    logic [31:0]         rdata2_q, rdata2_d;
    logic [31:0]         imm_q,    imm_d;
    logic [4:0]          rs_q,     rs_d;
    logic [4:0]          rt_q,     rt_d;
    logic [4:0]          rd_q,     rd_d;
    logic                valid_q,  valid_d;

    assign w_ctrl_in = {bus.regDst, bus.memRead, bus.memtoReg,
                        bus.memWrite, bus.aluSrc, bus.regWrite};

    // Next-state selection: flush squashes, hold freezes, otherwise capture
    always_comb begin
        ctrl_d   = ctrl_q;
        aluop_d  = aluop_q;
        pc4_d    = pc4_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        valid_d  = valid_q;

        if (bus.flush) begin
            // Squashed: payload still captured, it is simply never used
            ctrl_d   = '0;
            aluop_d  = 2'b00;
            valid_d  = 1'b0;
            pc4_d    = bus.pc4;
            rdata1_d = bus.rdata1;
            rdata2_d = bus.rdata2;
            imm_d    = bus.imm;
            rs_d     = bus.rs;
            rt_d     = bus.rt;
            rd_d     = bus.rd;
        end else if (!bus.hold) begin
            // A bubble (id_valid=0) never carries live control bits downstream
            ctrl_d   = bus.id_valid ? w_ctrl_in : '0;
            aluop_d  = bus.id_valid ? bus.aluop : 2'b00;
            valid_d  = bus.id_valid;
            pc4_d    = bus.pc4;
            rdata1_d = bus.rdata1;
            rdata2_d = bus.rdata2;
            imm_d    = bus.imm;
            rs_d     = bus.rs;
            rt_d     = bus.rt;
            rd_d     = bus.rd;
        end
    end

    // Pipeline flops with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            aluop_q  <= 2'b00;
            pc4_q    <= 32'd0;
            rdata1_q <= 32'd0;
            rdata2_q <= 32'd0;
            imm_q    <= 32'd0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            valid_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            aluop_q  <= aluop_d;
            pc4_q    <= pc4_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.regDst_ex   = ctrl_q[5];
    assign bus.memRead_ex  = ctrl_q[4];
    assign bus.memtoReg_ex = ctrl_q[3];
    assign bus.memWrite_ex = ctrl_q[2];
    assign bus.aluSrc_ex   = ctrl_q[1];
    assign bus.regWrite_ex = ctrl_q[0];
    assign bus.aluop_ex    = aluop_q;
    assign bus.pc4_ex      = pc4_q;
    assign bus.rdata1_ex   = rdata1_q;
    assign bus.rdata2_ex   = rdata2_q;
    assign bus.imm_ex      = imm_q;
    assign bus.rs_ex       = rs_q;
    assign bus.rt_ex       = rt_q;
    assign bus.rd_ex       = rd_q;
    assign bus.ex_valid    = valid_q;

    // Load-use flag is derived purely from registered state
    assign bus.ex_load     = ctrl_q[c_MEMREAD_B] & valid_q;

`ifdef ID_EX_PERF_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        w_bubble;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // A bubble enters EX on any non-hold edge that flushes or sees id_valid=0
    assign w_bubble     = !bus.hold && (bus.flush || !bus.id_valid);
    assign bubble_cnt_d = (w_bubble && (bubble_cnt_q != c_CNT_MAX))
                          ? bubble_cnt_q + 16'd1 : bubble_cnt_q;

    // Saturating bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Self-checking bench for id_ex_reg. Expected outputs come from
//               a small reference model and flow through a scoreboard queue.
//               Counter checks are compiled in with ID_EX_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_reg;

    typedef struct packed {
        logic [5:0]  ctrl;      // {regDst, memRead, memtoReg, memWrite, aluSrc, regWrite}
        logic [1:0]  aluop;
        logic [31:0] pc4;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        id_valid;
        logic        flush;
        logic        hold;
    } in_t;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [1:0]  aluop;
        logic [31:0] pc4;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
        logic        load;
    } out_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    out_t  model_q;
    out_t  exp_q[$];
    int    cnt_model;

    id_ex_if bus ();

    id_ex_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.ctrl   = {bus.regDst_ex, bus.memRead_ex, bus.memtoReg_ex,
                    bus.memWrite_ex, bus.aluSrc_ex, bus.regWrite_ex};
        o.aluop  = bus.aluop_ex;
        o.pc4    = bus.pc4_ex;
        o.rdata1 = bus.rdata1_ex;
        o.rdata2 = bus.rdata2_ex;
        o.imm    = bus.imm_ex;
        o.rs     = bus.rs_ex;
        o.rt     = bus.rt_ex;
        o.rd     = bus.rd_ex;
        o.valid  = bus.ex_valid;
        o.load   = bus.ex_load;
        return o;
    endfunction

    task automatic drive(input in_t i);
        {bus.regDst, bus.memRead, bus.memtoReg,
         bus.memWrite, bus.aluSrc, bus.regWrite} = i.ctrl;
        bus.aluop    = i.aluop;
        bus.pc4      = i.pc4;
        bus.rdata1   = i.rdata1;
        bus.rdata2   = i.rdata2;
        bus.imm      = i.imm;
        bus.rs       = i.rs;
        bus.rt       = i.rt;
        bus.rd       = i.rd;
        bus.id_valid = i.id_valid;
        bus.flush    = i.flush;
        bus.hold     = i.hold;
    endtask

    // Reference behaviour of one capture edge
    function automatic out_t predict(input out_t cur, input in_t i);
        out_t n;
        n = cur;
        if (i.flush || !i.hold) begin
            n.pc4    = i.pc4;
            n.rdata1 = i.rdata1;
            n.rdata2 = i.rdata2;
            n.imm    = i.imm;
            n.rs     = i.rs;
            n.rt     = i.rt;
            n.rd     = i.rd;
            if (i.flush || !i.id_valid) begin
                n.ctrl  = 6'd0;
                n.aluop = 2'b00;
                n.valid = 1'b0;
            end else begin
                n.ctrl  = i.ctrl;
                n.aluop = i.aluop;
                n.valid = 1'b1;
            end
        end
        n.load = n.ctrl[4] & n.valid;
        return n;
    endfunction

    function automatic in_t blank();
        in_t i;
        i = '0;
        i.pc4    = 32'h0000_1004;
        i.rdata1 = 32'hA5A5_0001;
        i.rdata2 = 32'h5A5A_0002;
        i.imm    = 32'hFFFF_FFF0;
        i.rs     = 5'd1;
        i.rt     = 5'd2;
        i.rd     = 5'd7;
        return i;
    endfunction

    task automatic check_out(input string tag, input out_t obs, input out_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef ID_EX_PERF_EN
        checks++;
        assert (bus.bubble_cnt === 16'(cnt_model)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, bus.bubble_cnt, cnt_model);
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One directed step: drive at the current (falling) time, push the
    // predicted result, compare after the next rising edge.
    task automatic step(input string tag, input in_t i);
        out_t got;
        drive(i);
        model_q = predict(model_q, i);
        if (!i.hold && (i.flush || !i.id_valid) && cnt_model < 65535)
            cnt_model++;
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        got = sample();
        check_out(tag, got, exp_q.pop_front());
        check_cnt({tag, "_cnt"});
        @(negedge clk);
    endtask

    task automatic reset_model();
        model_q   = '0;
        cnt_model = 0;
    endtask

    initial begin
        in_t  i;
        out_t zero;
        zero     = '0;
        checks   = 0;
        failures = 0;
        reset_model();
        rst_n    = 1'b0;
        drive(blank());
        #1;
        check_out("reset_initial", sample(), zero);
        check_cnt("reset_initial_cnt");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load
        i = blank();
        i.ctrl = 6'b000001; i.aluop = 2'b10; i.rdata1 = 32'h1234_5678;
        i.rs = 5'd3; i.id_valid = 1'b1;
        step("load_pre", i);

        // Asynchronous reset mid-cycle clears everything without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_out("reset_async", sample(), zero);
        @(negedge clk);
        rst_n = 1'b1;
        step("load_a", i);

        // Flush squashes a valid memRead/memWrite instruction
        i = blank();
        i.ctrl = 6'b010100; i.aluop = 2'b01; i.id_valid = 1'b1; i.flush = 1'b1;
        step("flush", i);

        // Load a valid instruction with rd=7, then hold while inputs move
        i = blank();
        i.ctrl = 6'b100011; i.aluop = 2'b11; i.rd = 5'd7; i.id_valid = 1'b1;
        step("load_b", i);
        i.rd = 5'd31; i.rdata2 = 32'hDEAD_BEEF; i.ctrl = 6'b011110;
        i.id_valid = 1'b0; i.hold = 1'b1;
        step("hold_1", i);
        i.pc4 = 32'h0000_2000;
        step("hold_2", i);
        i.imm = 32'h0000_0042;
        step("hold_3", i);
        i.hold = 1'b0; i.id_valid = 1'b1;
        step("hold_release", i);

        // Flush and hold together act as flush
        i = blank();
        i.ctrl = 6'b000001; i.aluop = 2'b10; i.id_valid = 1'b1;
        i.flush = 1'b1; i.hold = 1'b1;
        step("flush_hold", i);

        // Load-use flag follows memRead of a valid instruction
        i = blank();
        i.ctrl = 6'b011011; i.aluop = 2'b00; i.rt = 5'd9; i.id_valid = 1'b1;
        step("lw_load", i);
        i.ctrl = 6'b110011; i.aluop = 2'b11; i.id_valid = 1'b0;
        step("bubble_memread", i);

        // Reset in the middle of a hold sequence; first edge after is a load
        i = blank();
        i.ctrl = 6'b000011; i.aluop = 2'b01; i.id_valid = 1'b1; i.rd = 5'd12;
        step("load_c", i);
        i.hold = 1'b1; i.rd = 5'd20;
        step("hold_c", i);
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_out("reset_in_hold", sample(), zero);
        check_cnt("reset_in_hold_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        i.hold = 1'b0; i.rd = 5'd21;
        step("load_after_reset", i);

`ifdef ID_EX_PERF_EN
        // Saturation: a long run of bubbles must pin the counter at 16'hFFFF
        i = blank();
        drive(i);
        model_q = predict(model_q, i);
        repeat (65540) @(posedge clk);
        cnt_model = 65535;
        #1;
        check_out("sat_out", sample(), model_q);
        check_cnt("sat_cnt");
        @(negedge clk);
        step("sat_hold_wrap", i);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
